// File: rtl/distance_operand_streamer.sv
// Query-load then point-stream sequencer feeding the distance accumulator.
// Ports: clk/reset (async active-low), start + bases in; memRead/memAddr out, memData in;
//        data1/data2/dataValid/dataLast/pointIndex beat out; busy/done status out.
module distance_operand_streamer #(
    parameter int dataWidth          = 32,
    parameter int numberOfDimensions = 32,
    parameter int numberOfPoints     = 16,
    parameter int addrWidth          = 10
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [addrWidth-1:0]              queryBase,
    input  logic [addrWidth-1:0]              pointBase,
    output logic                              memRead,
    output logic [addrWidth-1:0]              memAddr,
    input  logic [dataWidth-1:0]              memData,
    output logic [dataWidth-1:0]              data1,
    output logic [dataWidth-1:0]              data2,
    output logic                              dataValid,
    output logic                              dataLast,
    output logic [$clog2(numberOfPoints):0]   pointIndex,
    output logic                              busy,
    output logic                              done
);

    localparam int DW = $clog2(numberOfDimensions);
    localparam int PW = $clog2(numberOfPoints) + 1;
    localparam logic [DW-1:0] DLAST = DW'(numberOfDimensions - 1);
    localparam logic [PW-1:0] PLAST = PW'(numberOfPoints - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_QUERY,
        STREAM,
        DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic [DW-1:0]          d_q, d_d;
    logic [PW-1:0]          p_q, p_d;
    logic [addrWidth-1:0]   off_q, off_d;
    logic [addrWidth-1:0]   qbase_q, qbase_d;
    logic [addrWidth-1:0]   pbase_q, pbase_d;
    logic [addrWidth-1:0]   lastAddr_q;
    logic                   done_q, done_d;
    logic                   cap_q;
    logic [DW-1:0]          capIdx_q;
    logic [dataWidth-1:0]   qreg_q [numberOfDimensions];
    logic                   valid_q;
    logic                   last_q;
    logic [dataWidth-1:0]   d1_q;
    logic [dataWidth-1:0]   d2_q;
    logic [PW-1:0]          pidx_q;

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        p_d     = p_q;
        off_d   = off_q;
        qbase_d = qbase_q;
        pbase_d = pbase_q;
        done_d  = 1'b0;
        memRead = 1'b0;
        memAddr = lastAddr_q;
        unique case (state_q)
            IDLE: begin
                // The done cycle itself still reads as IDLE; refuse start there.
                if (start && !done_q) begin
                    state_d = LOAD_QUERY;
                    d_d     = '0;
                    qbase_d = queryBase;
                    pbase_d = pointBase;
                end
            end
            LOAD_QUERY: begin
                memRead = 1'b1;
                memAddr = qbase_q + addrWidth'(d_q);
                d_d     = d_q + DW'(1);
                if (d_q == DLAST) begin
                    state_d = STREAM;
                    d_d     = '0;
                    p_d     = '0;
                    off_d   = '0;
                end
            end
            STREAM: begin
                memRead = 1'b1;
                memAddr = pbase_q + off_q;
                off_d   = off_q + addrWidth'(1);
                d_d     = d_q + DW'(1);
                if (d_q == DLAST) begin
                    d_d = '0;
                    p_d = p_q + PW'(1);
                    if (p_q == PLAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            d_q        <= '0;
            p_q        <= '0;
            off_q      <= '0;
            qbase_q    <= '0;
            pbase_q    <= '0;
            lastAddr_q <= '0;
            done_q     <= 1'b0;
            cap_q      <= 1'b0;
            capIdx_q   <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            d1_q       <= '0;
            d2_q       <= '0;
            pidx_q     <= '0;
            for (int i = 0; i < numberOfDimensions; i++) begin
                qreg_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            d_q        <= d_d;
            p_q        <= p_d;
            off_q      <= off_d;
            qbase_q    <= qbase_d;
            pbase_q    <= pbase_d;
            lastAddr_q <= memAddr;
            done_q     <= done_d;
            // Query word arrives the cycle after its request.
            cap_q      <= (state_q == LOAD_QUERY);
            capIdx_q   <= d_q;
            if (cap_q) begin
                qreg_q[capIdx_q] <= memData;
            end
            valid_q <= (state_q == STREAM);
            last_q  <= (state_q == STREAM) && (d_q == DLAST);
            if (state_q == STREAM) begin
                d1_q   <= qreg_q[d_q];
                pidx_q <= p_q;
            end
            if (valid_q) begin
                d2_q <= memData;
            end
        end
    end

    // Candidate word is only valid during its beat; hold it afterwards.
    assign data2      = valid_q ? memData : d2_q;
    assign data1      = d1_q;
    assign dataValid  = valid_q;
    assign dataLast   = last_q;
    assign pointIndex = pidx_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

endmodule
